// File: rtl/f3m_pkg.sv
// f3m_pkg: shared constants and GF(3) / GF(3^97) trit helpers.
//  Trit encoding: 00 = 0, 01 = 1, 10 = 2. Code 11 is illegal; every helper
//  treats it as 0 and none of them ever returns 11.
//  M     field extension degree (97)
//  LEN   width of a field element vector (2*M bits, trit i = bits [2i+1:2i])
//  RLEN  width of the Euclid remainder registers (one extra trit for x^M)
package f3m_pkg;

  localparam int M    = 97;
  localparam int LEN  = 2 * M;
  localparam int RLEN = LEN + 2;

  localparam logic [1:0] T0 = 2'b00;
  localparam logic [1:0] T1 = 2'b01;
  localparam logic [1:0] T2 = 2'b10;

  // P(x) = x^97 + x^12 + 2, held in the extended remainder width.
  localparam logic [RLEN-1:0] MODP = (RLEN'(1) << (2 * M)) | (RLEN'(1) << 24) | RLEN'(2);

  // Number of Euclid steps per inversion.
  localparam logic [7:0] STEPS = 8'(2 * M);

  // FSM encoding.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [1:0] f3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (s)
      3'd1, 3'd4: f3_add = T1;
      3'd2, 3'd5: f3_add = T2;
      default:    f3_add = T0;
    endcase
  endfunction

  function automatic logic [1:0] f3_neg(input logic [1:0] a);
    case (a)
      T1:      f3_neg = T2;
      T2:      f3_neg = T1;
      default: f3_neg = T0;
    endcase
  endfunction

  function automatic logic [1:0] f3_sub(input logic [1:0] a, input logic [1:0] b);
    f3_sub = f3_add(a, f3_neg(b));
  endfunction

  function automatic logic [1:0] f3_mul(input logic [1:0] a, input logic [1:0] b);
    if (a == T0 || b == T0 || a == 2'b11 || b == 2'b11) f3_mul = T0;
    else                                                f3_mul = (a == b) ? T1 : T2;
  endfunction

  function automatic logic [LEN-1:0] f3m_add(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_add(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  function automatic logic [LEN-1:0] f3m_sub(input logic [LEN-1:0] a, input logic [LEN-1:0] b);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_sub(a[2*i +: 2], b[2*i +: 2]);
    return r;
  endfunction

  // Multiply every trit of v by the scalar trit k.
  function automatic logic [LEN-1:0] f3m_scale(input logic [LEN-1:0] v, input logic [1:0] k);
    logic [LEN-1:0] r;
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = f3_mul(v[2*i +: 2], k);
    return r;
  endfunction

endpackage

// File: rtl/f3m_mulx_modp.sv
// f3m_mulx_modp: combinational multiply / divide by x modulo P(x) = x^97 + x^12 + 2.
//  v     in   LEN  field element
//  mulx  out  LEN  x*v mod P
//  divx  out  LEN  v/x mod P
//  x^97 == 2*x^12 + 1, so the trit shifted out of the top adds into trit 0
//  and subtracts from trit 12. Division first adds v0*P (which clears the
//  constant term), then shifts down: trit 96 gets v0, trit 11 gets v12 + v0.
module f3m_mulx_modp
  import f3m_pkg::*;
(
  input  logic [LEN-1:0] v,
  output logic [LEN-1:0] mulx,
  output logic [LEN-1:0] divx
);

  logic [1:0] top;
  logic [1:0] low;

  always_comb begin
    top  = f3_add(T0, v[LEN-1 -: 2]);
    low  = f3_add(T0, v[1:0]);

    mulx        = {v[LEN-3:0], T0};
    mulx[1:0]   = top;
    mulx[25:24] = f3_sub(v[23:22], top);

    divx             = {T0, v[LEN-1:2]};
    divx[LEN-1 -: 2] = low;
    divx[23:22]      = f3_add(v[25:24], low);
  end

endmodule

// File: rtl/f3m_inverse.sv
// f3m_inverse: multiplicative inverse in GF(3^97), modulus x^97 + x^12 + 2.
//  clk        in   1    clock, rising edge
//  reset      in   1    asynchronous, active low; release starts a computation
//  A          in   LEN  operand, sampled once after reset release
//  C          out  LEN  A^-1 mod P (0 for A == 0), registered, held until reset
//  done       out  1    only when F3M_INV_DONE_EN is defined: high in DONE
//  dbg_state  out  2    current FSM state (S_IDLE/S_LOAD/S_RUN/S_DONE)
// Control: there is no valid/ready pair. Releasing reset is the start
// request; C is final 197 rising edges after release and stays there until
// the next reset. A is read only in LOAD.
// Algorithm: constant-time extended Euclid with R and S aligned so that the
// lead trit sits at position M. Invariants R == A*U*x^e and S == A*V*x^e
// (mod P) hold with a common e; after 2*M steps R = c*x^M with e = M, so
// A^-1 = c^-1*U = c*U.
module f3m_inverse
  import f3m_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [LEN-1:0] A,
  output logic [LEN-1:0] C,
`ifdef F3M_INV_DONE_EN
  output logic           done,
`endif
  output logic [1:0]     dbg_state
);

  logic [1:0]      state;
  logic [7:0]      cnt;
  logic [7:0]      d;
  logic [RLEN-1:0] r_q, s_q;
  logic [LEN-1:0]  u_q, v_q;

  logic [1:0]      r_lead, s_lead, q;
  logic [LEN-1:0]  s_red, v_red, c_norm;
  logic [RLEN-1:0] r_sh, s_sh;
  logic [LEN-1:0]  u_mulx, u_divx, v_mulx, unused_v_divx;

  always_comb begin
    r_lead = r_q[RLEN-1 -: 2];
    s_lead = s_q[RLEN-1 -: 2];
    // r^-1 == r in GF(3), so s/r == s*r.
    q      = f3_mul(s_lead, r_lead);
    // The lead trit of S - q*R is zero by construction and is shifted out,
    // so only the low LEN bits are computed.
    s_red  = f3m_sub(s_q[LEN-1:0], f3m_scale(r_q[LEN-1:0], q));
    v_red  = f3m_sub(v_q, f3m_scale(u_q, q));
    r_sh   = {r_q[LEN-1:0], T0};
    s_sh   = {s_red, T0};
    c_norm = f3m_scale(u_q, r_lead);
  end

  f3m_mulx_modp u_path (
    .v    (u_q),
    .mulx (u_mulx),
    .divx (u_divx)
  );

  // On a swap the new U is x times the freshly reduced V.
  f3m_mulx_modp v_path (
    .v    (v_red),
    .mulx (v_mulx),
    .divx (unused_v_divx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      d     <= '0;
      r_q   <= '0;
      s_q   <= '0;
      u_q   <= '0;
      v_q   <= '0;
      C     <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_LOAD;
        S_LOAD: begin
          r_q   <= {T0, A};
          s_q   <= MODP;
          u_q   <= LEN'(1);
          v_q   <= '0;
          d     <= '0;
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (cnt == STEPS) begin
            C     <= c_norm;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 8'd1;
            if (r_lead == T0) begin
              r_q <= r_sh;
              u_q <= u_mulx;
              d   <= d + 8'd1;
            end else if (d == 8'd0) begin
              r_q <= s_sh;
              s_q <= r_q;
              u_q <= v_mulx;
              v_q <= u_q;
              d   <= 8'd1;
            end else begin
              s_q <= s_sh;
              v_q <= v_red;
              u_q <= u_divx;
              d   <= d - 8'd1;
            end
          end
        end
        S_DONE:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

`ifdef F3M_INV_DONE_EN
  assign done = (state == S_DONE);
`endif

endmodule

// File: tb/tb_f3m_inverse.sv
// tb_f3m_inverse: scoreboard bench for f3m_inverse. The driver pushes the
// expected inverse (directed constants or a polynomial extended-Euclid
// reference) into exp_q; the monitor pops and compares 200 cycles after each
// reset release, and also checks C*A mod P == 1 for nonzero A.
`timescale 1ns/1ps
module tb_f3m_inverse;

  localparam int W = 194;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] C;
  logic [1:0]   dbg_state;
`ifdef F3M_INV_DONE_EN
  logic         done;
`endif

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] a_q[$];

  // clock / reset
  always #5 clk = ~clk;

  f3m_inverse dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .C         (C),
`ifdef F3M_INV_DONE_EN
    .done      (done),
`endif
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // reference model: plain polynomial arithmetic over F3
  function automatic int deg(input int v[200]);
    for (int i = 199; i >= 0; i--) if (v[i] != 0) return i;
    return -1;
  endfunction

  function automatic logic [W-1:0] ref_inv(input logic [W-1:0] a);
    int r0[200];
    int r1[200];
    int t0[200];
    int t1[200];
    int tmp[200];
    int d0, d1, sh, q, c;
    logic [1:0] tr;
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < 200; i++) begin
      r0[i] = 0; r1[i] = 0; t0[i] = 0; t1[i] = 0;
    end
    r0[97] = 1; r0[12] = 1; r0[0] = 2;
    for (int i = 0; i < 97; i++) begin
      tr = a[2*i +: 2];
      r1[i] = int'(tr);
    end
    t1[0] = 1;
    d1 = deg(r1);
    if (d1 < 0) return res;
    while (d1 > 0) begin
      d0 = deg(r0);
      while (d0 >= d1) begin
        sh = d0 - d1;
        q  = (r0[d0] * r1[d1]) % 3;
        for (int i = 0; i + sh < 200; i++) begin
          r0[i+sh] = (r0[i+sh] + 6 - q * r1[i]) % 3;
          t0[i+sh] = (t0[i+sh] + 6 - q * t1[i]) % 3;
        end
        d0 = deg(r0);
      end
      tmp = r0; r0 = r1; r1 = tmp;
      tmp = t0; t0 = t1; t1 = tmp;
      d1 = deg(r1);
    end
    c = (d1 == 0) ? r1[0] : 0;
    for (int i = 0; i < 97; i++) res[2*i +: 2] = 2'((t1[i] * c) % 3);
    return res;
  endfunction

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int p[200];
    int t;
    logic [1:0] ta, tb;
    logic [W-1:0] res;
    for (int i = 0; i < 200; i++) p[i] = 0;
    for (int i = 0; i < 97; i++) begin
      ta = a[2*i +: 2];
      for (int j = 0; j < 97; j++) begin
        tb = b[2*j +: 2];
        p[i+j] += int'(ta) * int'(tb);
      end
    end
    // x^97 = 2*x^12 + 1
    for (int k = 192; k >= 97; k--) begin
      t = p[k] % 3;
      p[k] = 0;
      p[k-85] += 2 * t;
      p[k-97] += t;
    end
    res = '0;
    for (int i = 0; i < 97; i++) res[2*i +: 2] = 2'(p[i] % 3);
    return res;
  endfunction

  // monitor
  initial begin : monitor
    int cyc;
    logic [W-1:0] e;
    logic [W-1:0] a;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc = 0;
      end else begin
        cyc++;
`ifdef F3M_INV_DONE_EN
        if (cyc == 1) check("done_early", W'(done), '0);
        if (cyc == 200) check("done_final", W'(done), W'(1));
`endif
        if (cyc == 200) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue, required one pending entry");
          end else begin
            e = exp_q.pop_front();
            a = a_q.pop_front();
            check("result", C, e);
            if (a != '0) check("product", ref_mul(a, C), W'(1));
          end
        end
      end
    end
  end

  // driver tasks
  task automatic hold_reset(input logic [W-1:0] a);
    @(negedge clk);
    #2 reset = 1'b0;
    A = a;
    repeat (2) @(negedge clk);
    check("reset_C", C, '0);
    check("reset_state", W'(dbg_state), '0);
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] e);
    hold_reset(a);
    exp_q.push_back(e);
    a_q.push_back(a);
    #2 reset = 1'b1;
    repeat (202) @(negedge clk);
  endtask

  logic [W-1:0] v_x_inv;
  logic [W-1:0] v_964_inv;
  logic [W-1:0] ra;

  initial begin : driver
    v_x_inv   = (W'(1) << 192) | (W'(1) << 22);
    v_964_inv = 194'h65450169824811252a919a8a02964184221a1562655252a9;

    run(W'(1), W'(1));
    run(W'(2), W'(2));
    run(W'(4), v_x_inv);
    run(W'(12'h964), v_964_inv);
    run('0, '0);

    // abort mid-run, then recompute from the new operand
    hold_reset(W'(12'h964));
    #2 reset = 1'b1;
    repeat (50) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("abort_C", C, '0);
    check("abort_state", W'(dbg_state), '0);
    A = W'(4);
    exp_q.push_back(v_x_inv);
    a_q.push_back(W'(4));
    @(negedge clk);
    #2 reset = 1'b1;
    repeat (202) @(negedge clk);

    for (int n = 0; n < 250; n++) begin
      ra = '0;
      for (int i = 0; i < 97; i++) ra[2*i +: 2] = 2'($urandom_range(0, 2));
      if (ra == '0) ra = W'(1);
      run(ra, ref_inv(ra));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
